// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited word fetch with an in-order response FIFO and PC-tagged decode output.
// Latency: request accept to ins_valid_o is at least 2 cycles; decode backpressure holds the head, and issue stops once credits run out.

// Generic synchronous FIFO with flush; registered read port, one push and one pop per cycle.
// Latency: a push is visible on rdat_o the next cycle; pushing while full without a pop is dropped, and popping while empty is ignored.
module ifetch_queue_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdat_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdat_o,
    output logic [AW:0]   count_o,
    output logic          empty_o
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !reset_i) begin
            mem_q[wr_ptr_q] <= wdat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign rdat_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
endmodule

module ifetch_queue #(
    parameter int unsigned C_FIFO_DEPTH_X = 2,
    parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        ireqvalid_o,
    input  logic        ireqready_i,
    output logic [31:0] ireqaddr_o,
    input  logic        irspvalid_i,
    input  logic [31:0] irspdata_i,
    input  logic        irsperr_i,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_pc_o,
    output logic        ins_err_o,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i
);
    localparam int unsigned   CW    = C_FIFO_DEPTH_X + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1 << C_FIFO_DEPTH_X);

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] dat;
    } ins_ent_t;

    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   ret_pc_q;
    logic [31:0]   ret_pc_d;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] outst_d;
    logic [CW-1:0] disc_q;
    logic [CW-1:0] disc_d;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   credit_used;
    logic          fifo_empty;
    logic          req_acc;
    logic          rsp_keep;
    logic          fifo_pop;
    logic [31:0]   jump_tgt;
    logic          jump_lsb_unused;
    ins_ent_t      push_ent;
    ins_ent_t      head_ent;

    assign jump_tgt        = {jump_addr_i[31:2], 2'b00};
    assign jump_lsb_unused = ^jump_addr_i[1:0];

    // Every issued request owns a FIFO slot until its response is popped or dropped.
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, outst_q};
    assign ireqvalid_o = !reset_i && (credit_used < {1'b0, DEPTH});
    assign ireqaddr_o  = fetch_pc_q;
    assign req_acc     = ireqvalid_o && ireqready_i;

    assign rsp_keep = irspvalid_i && (disc_q == '0) && !jump_i;
    assign fifo_pop = ins_valid_o && ins_ready_i && !jump_i;
    assign push_ent = '{err: irsperr_i, pc: ret_pc_q, dat: irspdata_i};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        disc_d     = disc_q;
        outst_d    = outst_q + CW'(req_acc) - CW'(irspvalid_i);
        if (jump_i) begin
            fetch_pc_d = jump_tgt;
            ret_pc_d   = jump_tgt;
            disc_d     = outst_d;
        end else begin
            if (req_acc) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_keep) begin
                ret_pc_d = ret_pc_q + 32'd4;
            end
            if (irspvalid_i && (disc_q != '0)) begin
                disc_d = disc_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q <= C_RESET_VECTOR;
            ret_pc_q   <= C_RESET_VECTOR;
            outst_q    <= '0;
            disc_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
        end
    end

    ifetch_queue_fifo #(
        .W  ($bits(ins_ent_t)),
        .AW (C_FIFO_DEPTH_X)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (jump_i),
        .push_i  (rsp_keep),
        .wdat_i  (push_ent),
        .pop_i   (fifo_pop),
        .rdat_o  (head_ent),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    assign ins_valid_o = !fifo_empty;
    assign ins_o       = head_ent.dat;
    assign ins_pc_o    = head_ent.pc;
    assign ins_err_o   = head_ent.err;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: an in-order memory model plus a queue-level reference model, vector table and directed sequences.
module tb_ifetch_queue;
    localparam logic [31:0] RV0 = 32'h0000_0000;
    localparam logic [31:0] RV1 = 32'hFFFF_FFF8;

    logic        clk_i = 1'b0;
    logic        reset_i, ireqready_i, irspvalid_i, irsperr_i, ins_ready_i, jump_i;
    logic [31:0] irspdata_i, jump_addr_i;
    logic        ireqvalid_o, ins_valid_o, ins_err_o;
    logic [31:0] ireqaddr_o, ins_o, ins_pc_o;
    logic        reqv1, insv1, dut1_err_unused;
    logic [31:0] addr1, pc1, dut1_ins_unused;

    always #5 clk_i = ~clk_i;

    ifetch_queue #(.C_FIFO_DEPTH_X(2), .C_RESET_VECTOR(RV0)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ireqvalid_o(ireqvalid_o), .ireqready_i(ireqready_i), .ireqaddr_o(ireqaddr_o),
        .irspvalid_i(irspvalid_i), .irspdata_i(irspdata_i), .irsperr_i(irsperr_i),
        .ins_valid_o(ins_valid_o), .ins_ready_i(ins_ready_i), .ins_o(ins_o),
        .ins_pc_o(ins_pc_o), .ins_err_o(ins_err_o),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i)
    );

    ifetch_queue #(.C_FIFO_DEPTH_X(2), .C_RESET_VECTOR(RV1)) dut1 (
        .clk_i(clk_i), .reset_i(reset_i),
        .ireqvalid_o(reqv1), .ireqready_i(ireqready_i), .ireqaddr_o(addr1),
        .irspvalid_i(irspvalid_i), .irspdata_i(irspdata_i), .irsperr_i(irsperr_i),
        .ins_valid_o(insv1), .ins_ready_i(ins_ready_i), .ins_o(dut1_ins_unused),
        .ins_pc_o(pc1), .ins_err_o(dut1_err_unused),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i)
    );

    typedef struct { logic [31:0] dat; logic err; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; bit live; } infl_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        bit rst; bit jmp; logic [31:0] ja; bit rdy; bit irdy;
        bit e_reqv; logic [31:0] e_addr; bit e_insv; logic [31:0] e_pc;
    } vec_t;

    ent_t        m_fifo[$];
    infl_t       m_infl[$];
    mreq_t       memq[$];
    vec_t        vt[$];
    logic [31:0] m_pc;
    bit          model_on = 1'b0;
    int          errors = 0, checks = 0, cycnum = 0, dly = 1;
    bit          rnd_dly = 1'b0, rnd_err = 1'b0;
    logic [31:0] err_addr = 32'h1;
    logic        s_reqv, s_insv, s_err, s1_reqv, s1_insv;
    logic [31:0] s_addr, s_pc, s_ins, s1_addr, s1_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cycnum);
        end
    endtask

    // One clock: drive inputs, sample, check against the model, advance model and memory.
    task automatic cyc(input bit rst, input bit jmp, input logic [31:0] ja, input bit rdy, input bit irdy);
        bit          rsp, e_reqv, m_acc, keep, m_pop;
        infl_t       h;
        logic [31:0] raddr;
        int          d;
        reset_i = rst; jump_i = jmp; jump_addr_i = ja; ireqready_i = rdy; ins_ready_i = irdy;
        rsp   = 1'b0;
        raddr = 32'h0;
        if (!rst && memq.size() > 0) begin
            if (memq[0].due <= cycnum) begin
                rsp   = 1'b1;
                raddr = memq[0].addr;
            end
        end
        irspvalid_i = rsp;
        irspdata_i  = rsp ? mem_word(raddr) : $urandom;
        irsperr_i   = rsp ? ((raddr == err_addr) || (rnd_err && raddr[4:2] == 3'd5)) : 1'b1;
        #1;
        s_reqv = ireqvalid_o; s_addr = ireqaddr_o; s_insv = ins_valid_o;
        s_pc = ins_pc_o; s_ins = ins_o; s_err = ins_err_o;
        s1_reqv = reqv1; s1_addr = addr1; s1_insv = insv1; s1_pc = pc1;
        e_reqv = !rst && (m_fifo.size() + m_infl.size() < 4);
        if (model_on) begin
            chk("m_ireqvalid", s_reqv, e_reqv);
            chk("m_ireqaddr", s_addr, m_pc);
            chk("m_ins_valid", s_insv, m_fifo.size() > 0);
            if (m_fifo.size() > 0) begin
                chk("m_ins_pc", s_pc, m_fifo[0].pc);
                chk("m_ins", s_ins, m_fifo[0].dat);
                chk("m_ins_err", s_err, m_fifo[0].err);
            end
        end
        if (rst) begin
            m_pc = RV0;
            m_fifo.delete(); m_infl.delete(); memq.delete();
            model_on = 1'b1;
        end else begin
            m_acc = e_reqv && rdy;
            keep  = 1'b0;
            if (rsp && m_infl.size() > 0) begin
                h    = m_infl.pop_front();
                keep = h.live && !jmp;
            end
            m_pop = (m_fifo.size() > 0) && irdy && !jmp;
            if (jmp) begin
                m_fifo.delete();
                foreach (m_infl[i]) m_infl[i].live = 1'b0;
                if (m_acc) m_infl.push_back('{addr: m_pc, live: 1'b0});
                m_pc = {ja[31:2], 2'b00};
            end else begin
                if (m_pop) void'(m_fifo.pop_front());
                if (keep) m_fifo.push_back('{dat: irspdata_i, err: irsperr_i, pc: h.addr});
                if (m_acc) begin
                    m_infl.push_back('{addr: m_pc, live: 1'b1});
                    m_pc = m_pc + 32'd4;
                end
            end
            if (rsp) void'(memq.pop_front());
            if (ireqvalid_o && ireqready_i) begin
                d = rnd_dly ? int'($urandom_range(1, 4)) : dly;
                memq.push_back('{addr: ireqaddr_o, due: cycnum + d});
            end
        end
        @(posedge clk_i);
        #1;
        cycnum++;
    endtask

    task automatic first_pc(input string nm, input logic [31:0] exp, input bit use1);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (use1 ? s1_insv : s_insv) begin
                seen = 1'b1;
                chk(nm, use1 ? s1_pc : s_pc, exp);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no instruction within 20 cycles, want pc %h", nm, exp);
        end
    endtask

    function automatic vec_t v(bit rst, bit rdy, bit irdy, bit er, logic [31:0] ea, bit ei, logic [31:0] ep);
        return '{rst: rst, jmp: 1'b0, ja: 32'h0, rdy: rdy, irdy: irdy,
                 e_reqv: er, e_addr: ea, e_insv: ei, e_pc: ep};
    endfunction

    initial begin
        logic [31:0] rv_exp [4];
        int k;
        rv_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        // Streaming after reset, then fill with decode stalled and a single pop.
        vt.push_back(v(1, 1, 1, 0, 32'h00, 0, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 32'h00, 0, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 32'h04, 0, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 32'h08, 1, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 32'h0C, 1, 32'h4));
        vt.push_back(v(0, 1, 1, 1, 32'h10, 1, 32'h8));
        vt.push_back(v(1, 1, 0, 0, 32'h14, 1, 32'hC));
        vt.push_back(v(1, 1, 0, 0, 32'h00, 0, 32'h0));
        vt.push_back(v(0, 1, 0, 1, 32'h00, 0, 32'h0));
        vt.push_back(v(0, 1, 0, 1, 32'h04, 0, 32'h0));
        vt.push_back(v(0, 1, 0, 1, 32'h08, 1, 32'h0));
        vt.push_back(v(0, 1, 0, 1, 32'h0C, 1, 32'h0));
        vt.push_back(v(0, 1, 0, 0, 32'h10, 1, 32'h0));
        vt.push_back(v(0, 1, 0, 0, 32'h10, 1, 32'h0));
        vt.push_back(v(0, 1, 1, 0, 32'h10, 1, 32'h0));
        vt.push_back(v(0, 1, 0, 1, 32'h10, 1, 32'h4));
        vt.push_back(v(0, 1, 0, 0, 32'h14, 1, 32'h4));
        vt.push_back(v(0, 1, 0, 0, 32'h14, 1, 32'h4));

        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        foreach (vt[i]) begin
            cyc(vt[i].rst, vt[i].jmp, vt[i].ja, vt[i].rdy, vt[i].irdy);
            chk($sformatf("tbl%0d_reqv", i), s_reqv, vt[i].e_reqv);
            chk($sformatf("tbl%0d_addr", i), s_addr, vt[i].e_addr);
            chk($sformatf("tbl%0d_insv", i), s_insv, vt[i].e_insv);
            if (vt[i].e_insv) chk($sformatf("tbl%0d_pc", i), s_pc, vt[i].e_pc);
        end

        // Jump with three slow responses in flight.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        dly = 5;
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_1002, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("jmp_reqv", s_reqv, 1'b1);
        chk("jmp_addr", s_addr, 32'h0000_1000);
        first_pc("jmp_first_pc", 32'h0000_1000, 1'b0);

        // Jump coinciding with a response and a pop while one entry is queued.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        dly = 1;
        repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b1);
        chk("j2_pre_insv", s_insv, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("j2_post_insv", s_insv, 1'b0);
        chk("j2_post_addr", s_addr, 32'h0000_2000);
        first_pc("j2_first_pc", 32'h0000_2000, 1'b0);

        // Access fault on pc 0x8 only.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        err_addr = 32'h8;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (s_insv) begin
                chk($sformatf("err_pc%0d", k), s_pc, 32'(k * 4));
                chk($sformatf("err_flag%0d", k), s_err, k == 2);
                k++;
            end
        end
        chk("err_delivered", k, 8);
        err_addr = 32'h1;

        // Reset vector near the top of the address space, then reset mid-stream.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (s1_insv && k < 4) begin
                chk($sformatf("rv_pc%0d", k), s1_pc, rv_exp[k]);
                k++;
            end
        end
        chk("rv_count", k, 4);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rst_mid_insv1", s1_insv, 1'b0);
        chk("rst_mid_insv0", s_insv, 1'b0);
        chk("rst_mid_reqv1", s1_reqv, 1'b1);
        chk("rst_mid_addr1", s1_addr, RV1);
        first_pc("rst_mid_first_pc", RV1, 1'b1);

        // Random traffic against the reference model.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        rnd_dly = 1'b1;
        rnd_err = 1'b1;
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
